// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer
// Drives the accumulator SRAM write/read/add strobes, the write/read
// addresses and the per-column write mask for one activation tile leaving
// an N x N systolic MAC array.
//
// Position model: after a start is accepted the sequencer steps through
// MUL_SIZE FILL slots and then M+MUL_SIZE-1 OUTPUT slots (output index k).
// Every cycle without stall advances exactly one slot. A stalled cycle
// holds the position and emits no strobes, so resuming replays the
// identical sequence.
//
// The state/counter registers always describe the slot whose strobes are
// currently on the outputs. The output registers are loaded with the
// decode of the *next* slot, so every output is registered and still
// lines up with the slot it belongs to.
//
// Accumulate-mode reads run RD_LAT slots ahead of their writes. The read
// index is derived from the same slot position, so the first reads land in
// the last RD_LAT FILL slots and stalls delay reads and writes alike.

module accumulator_sequencer #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 10,
  parameter int CNT_W    = 10,
  parameter int RD_LAT   = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [CNT_W-1:0]    num_rows_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                accumulate_i,
  input  logic                stall_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                write_accumulator_o,
  output logic                read_accumulator_o,
  output logic                accumulator_add_o,
  output logic [ADDR_W-1:0]   accumulator_addr_wr_o,
  output logic [ADDR_W-1:0]   accumulator_addr_rd_o,
  output logic [MUL_SIZE-1:0] accum_addr_mask_o
);

  // FILL counter covers 0..MUL_SIZE-1.
  localparam int FILL_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  // Output/read indices reach at most M + MUL_SIZE - 2 + RD_LAT, which is
  // below M + 2*MUL_SIZE; one extra bit above CNT_W+FILL_W covers it.
  localparam int K_W    = CNT_W + FILL_W + 1;

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(MUL_SIZE - 1);
  localparam logic [K_W-1:0]    N_K       = K_W'(MUL_SIZE);
  localparam logic [K_W-1:0]    RD_LAT_K  = K_W'(RD_LAT);
  localparam logic [K_W-1:0]    TWO_K     = K_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // Sequencer position and captured tile parameters
  state_t              state_reg,  state_next;
  logic [FILL_W-1:0]   fill_reg,   fill_next;
  logic [K_W-1:0]      k_reg,      k_next;
  logic [K_W-1:0]      last_k_reg, last_k_next;
  logic [CNT_W-1:0]    rows_reg,   rows_next;
  logic [ADDR_W-1:0]   base_reg,   base_next;
  logic                acc_reg,    acc_next;
  logic                done_event;

  // Registered outputs
  logic                busy_reg,    busy_next;
  logic                done_reg,    done_next;
  logic                wr_reg,      wr_next;
  logic                rd_reg,      rd_next;
  logic                add_reg,     add_next;
  logic [ADDR_W-1:0]   addr_wr_reg, addr_wr_next;
  logic [ADDR_W-1:0]   addr_rd_reg, addr_rd_next;
  logic [MUL_SIZE-1:0] mask_reg,    mask_next;

  // Read look-ahead decode for the next slot
  logic [K_W-1:0]      rd_idx;
  logic                rd_valid;

  // Per-column window decode for the next output index
  logic [MUL_SIZE-1:0] col_hit;

  // Address arithmetic wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] addr_at(input logic [ADDR_W-1:0] base,
                                                input logic [K_W-1:0]    idx);
    return base + ADDR_W'(idx);
  endfunction

  // Column j (mask bit MUL_SIZE-1-j) is live while j <= k < j + M:
  // ramp-up as the diagonal wavefront enters, ramp-down as it drains.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_SIZE; gi++) begin : g_col
      localparam logic [K_W-1:0] COL = K_W'(gi);
      assign col_hit[MUL_SIZE-1-gi] = (k_next >= COL) &&
                                      (k_next < (K_W'(rows_next) + COL));
    end
  endgenerate

  // State register: position counters and tile parameters captured on start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= ST_IDLE;
      fill_reg   <= '0;
      k_reg      <= '0;
      last_k_reg <= '0;
      rows_reg   <= '0;
      base_reg   <= '0;
      acc_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      fill_reg   <= fill_next;
      k_reg      <= k_next;
      last_k_reg <= last_k_next;
      rows_reg   <= rows_next;
      base_reg   <= base_next;
      acc_reg    <= acc_next;
    end
  end

  // Next-state logic: advance one slot per unstalled cycle
  always_comb begin
    state_next  = state_reg;
    fill_next   = fill_reg;
    k_next      = k_reg;
    last_k_next = last_k_reg;
    rows_next   = rows_reg;
    base_next   = base_reg;
    acc_next    = acc_reg;
    done_event  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !stall_i) begin
          if (num_rows_i != '0) begin
            state_next  = ST_FILL;
            fill_next   = '0;
            k_next      = '0;
            rows_next   = num_rows_i;
            last_k_next = K_W'(num_rows_i) + N_K - TWO_K;
            base_next   = base_addr_i;
            acc_next    = accumulate_i;
          end else begin
            // Empty tile: acknowledge with a bare done pulse.
            done_event = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (!stall_i) begin
          if (fill_reg == FILL_LAST) begin
            state_next = ST_OUTPUT;
            k_next     = '0;
          end else begin
            fill_next = fill_reg + FILL_W'(1);
          end
        end
      end
      ST_OUTPUT: begin
        if (!stall_i) begin
          if (k_reg == last_k_reg) begin
            state_next = ST_IDLE;
            done_event = 1'b1;
          end else begin
            k_next = k_reg + K_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode for the slot being entered; a stall emits nothing
  always_comb begin
    busy_next    = (state_next != ST_IDLE);
    done_next    = done_event;
    wr_next      = 1'b0;
    rd_next      = 1'b0;
    add_next     = 1'b0;
    addr_wr_next = addr_wr_reg;
    addr_rd_next = addr_rd_reg;
    mask_next    = '0;
    rd_idx       = '0;
    rd_valid     = 1'b0;

    // Read index for the next slot: RD_LAT ahead of the write index.
    if (state_next == ST_FILL) begin
      if ((K_W'(fill_next) + RD_LAT_K) >= N_K) begin
        rd_idx   = K_W'(fill_next) + RD_LAT_K - N_K;
        rd_valid = 1'b1;
      end
    end else if (state_next == ST_OUTPUT) begin
      rd_idx   = k_next + RD_LAT_K;
      rd_valid = (rd_idx <= last_k_next);
    end

    if (!stall_i && (state_next == ST_OUTPUT)) begin
      wr_next      = 1'b1;
      add_next     = acc_next;
      addr_wr_next = addr_at(base_next, k_next);
      mask_next    = col_hit;
    end

    if (!stall_i && acc_next && rd_valid) begin
      rd_next      = 1'b1;
      addr_rd_next = addr_at(base_next, rd_idx);
    end
  end

  // Output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wr_reg      <= 1'b0;
      rd_reg      <= 1'b0;
      add_reg     <= 1'b0;
      addr_wr_reg <= '0;
      addr_rd_reg <= '0;
      mask_reg    <= '0;
    end else begin
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      wr_reg      <= wr_next;
      rd_reg      <= rd_next;
      add_reg     <= add_next;
      addr_wr_reg <= addr_wr_next;
      addr_rd_reg <= addr_rd_next;
      mask_reg    <= mask_next;
    end
  end

  assign busy_o                = busy_reg;
  assign done_o                = done_reg;
  assign write_accumulator_o   = wr_reg;
  assign read_accumulator_o    = rd_reg;
  assign accumulator_add_o     = add_reg;
  assign accumulator_addr_wr_o = addr_wr_reg;
  assign accumulator_addr_rd_o = addr_rd_reg;
  assign accum_addr_mask_o     = mask_reg;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Testbench for accumulator_sequencer (MUL_SIZE=4, ADDR_W=10, RD_LAT=1).
// A slot-position model predicts every output each cycle; directed tiles
// are additionally pinned against hand-computed cycle/address/mask lists.

module tb_accumulator_sequencer;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int CW = 10;
  localparam int RL = 1;
  localparam int VW = 5 + 2 * AW + N;
  localparam int AMOD = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] rows;
  logic [AW-1:0] base;
  logic          acc;
  logic          stall;
  logic          busy;
  logic          done;
  logic          wr;
  logic          rd;
  logic          add;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  mask;

  int checks   = 0;
  int failures = 0;

  accumulator_sequencer #(
    .MUL_SIZE(N),
    .ADDR_W  (AW),
    .CNT_W   (CW),
    .RD_LAT  (RL)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .start_i              (start),
    .num_rows_i           (rows),
    .base_addr_i          (base),
    .accumulate_i         (acc),
    .stall_i              (stall),
    .busy_o               (busy),
    .done_o               (done),
    .write_accumulator_o  (wr),
    .read_accumulator_o   (rd),
    .accumulator_add_o    (add),
    .accumulator_addr_wr_o(wr_addr),
    .accumulator_addr_rd_o(rd_addr),
    .accum_addr_mask_o    (mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  // pos counts unstalled cycles since start acceptance (1 = first FILL
  // cycle). Write index k = pos-N-1, read index = k+RL.
  typedef struct packed {
    bit           busy;
    int           pos;
    int           m;
    int           base;
    bit           acc;
    bit           done;
    bit           wr;
    bit           rd;
    bit           add;
    int           wa;
    int           ra;
    logic [N-1:0] mask;
  } mstate_t;

  mstate_t ms;

  function automatic mstate_t model_step(mstate_t s, bit st, bit stl,
                                         int rows_v, int base_v, bit acc_v);
    mstate_t n   = s;
    bit      adv = 1'b0;
    int      k;
    int      ri;
    n.done = 1'b0;
    n.wr   = 1'b0;
    n.rd   = 1'b0;
    n.add  = 1'b0;
    n.mask = '0;
    if (s.busy) begin
      if (!stl) begin
        n.pos = s.pos + 1;
        if (n.pos > 2 * N + s.m - 1) begin
          n.busy = 1'b0;
          n.done = 1'b1;
        end else begin
          adv = 1'b1;
        end
      end
    end else if (st && !stl) begin
      if (rows_v == 0) begin
        n.done = 1'b1;
      end else begin
        n.busy = 1'b1;
        n.pos  = 1;
        n.m    = rows_v;
        n.base = base_v;
        n.acc  = acc_v;
        adv    = 1'b1;
      end
    end
    if (adv) begin
      k = n.pos - N - 1;
      if (k >= 0) begin
        n.wr  = 1'b1;
        n.add = n.acc;
        n.wa  = (n.base + k) % AMOD;
        for (int j = 0; j < N; j++)
          n.mask[N-1-j] = (j <= k) && (k - j < n.m);
      end
      ri = k + RL;
      if (n.acc && ri >= 0 && ri <= n.m + N - 2) begin
        n.rd = 1'b1;
        n.ra = (n.base + ri) % AMOD;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '0;
    else        ms <= model_step(ms, start, stall, int'(rows), int'(base), acc);
  end

  logic [VW-1:0] dut_vec;
  logic [VW-1:0] exp_vec;
  assign dut_vec = {busy, done, wr, rd, add, wr_addr, rd_addr, mask};
  assign exp_vec = {ms.busy, ms.done, ms.wr, ms.rd, ms.add,
                    AW'(ms.wa), AW'(ms.ra), ms.mask};

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL cycle_cmp t=%0t: got {busy,done,wr,rd,add,wa,ra,mask}=%h expected %h",
                 $time, dut_vec, exp_vec);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  int           wr_cyc_q[$];
  int           wr_addr_q[$];
  logic [N-1:0] wr_mask_q[$];
  int           wr_add_q[$];
  int           rd_cyc_q[$];
  int           rd_addr_q[$];
  int           done_cyc;

  // Called at a falling edge; that cycle is cycle 0 (start presented).
  // Logs strobes by cycle number relative to acceptance and returns at the
  // falling edge of the done cycle.
  task automatic run_tile(input string tag, input int m, input int b, input bit a,
                          input int stall_from, input int stall_len,
                          input int extra_start);
    wr_cyc_q.delete();
    wr_addr_q.delete();
    wr_mask_q.delete();
    wr_add_q.delete();
    rd_cyc_q.delete();
    rd_addr_q.delete();
    done_cyc = -1;
    rows  = CW'(m);
    base  = AW'(b);
    acc   = a;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      start = (n == extra_start);
      rows  = CW'($urandom);
      base  = AW'($urandom);
      acc   = 1'($urandom);
      stall = (n >= stall_from) && (n < stall_from + stall_len);
      if (wr) begin
        wr_cyc_q.push_back(n);
        wr_addr_q.push_back(int'(wr_addr));
        wr_mask_q.push_back(mask);
        wr_add_q.push_back(int'(add));
      end
      if (rd) begin
        rd_cyc_q.push_back(n);
        rd_addr_q.push_back(int'(rd_addr));
      end
      if (done) begin
        done_cyc = n;
        break;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    if (done_cyc < 0) chk({tag, "_timeout"}, 0, 1);
    $display("tile %s: M=%0d base=0x%0h acc=%0d writes=%0d reads=%0d done_cycle=%0d",
             tag, m, b, a, wr_cyc_q.size(), rd_cyc_q.size(), done_cyc);
  endtask

  // Writes expected on consecutive cycles from first_cyc at base, base+1, ...
  task automatic check_writes(input string tag, input int b, input int first_cyc,
                              input int count, input int exp_done, input int exp_add);
    chk({tag, "_nwr"}, wr_cyc_q.size(), count);
    chk({tag, "_done"}, done_cyc, exp_done);
    for (int i = 0; i < count && i < wr_cyc_q.size(); i++) begin
      chk($sformatf("%s_wcyc%0d", tag, i), wr_cyc_q[i], first_cyc + i);
      chk($sformatf("%s_waddr%0d", tag, i), wr_addr_q[i], (b + i) % AMOD);
      chk($sformatf("%s_add%0d", tag, i), wr_add_q[i], exp_add);
    end
  endtask

  logic [N-1:0] t1_mask [9];
  logic [N-1:0] t2_mask [5];
  logic [N-1:0] t9_mask [4];
  int           t4_cyc  [9];

  initial begin
    t1_mask = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b1111,
                4'b1111, 4'b0111, 4'b0011, 4'b0001};
    t2_mask = '{4'b1000, 4'b1100, 4'b0110, 4'b0011, 4'b0001};
    t9_mask = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    t4_cyc  = '{5, 6, 7, 8, 12, 13, 14, 15, 16};

    rst_n = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    rows  = '0;
    base  = '0;
    acc   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", longint'(dut_vec), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Overwrite, M > N: full region present
    run_tile("t1", 6, 'h10, 1'b0, 0, 0, 0);
    check_writes("t1", 'h10, 5, 9, 14, 0);
    chk("t1_nrd", rd_cyc_q.size(), 0);
    for (int i = 0; i < 9 && i < wr_mask_q.size(); i++)
      chk($sformatf("t1_mask%0d", i), wr_mask_q[i], t1_mask[i]);
    @(negedge clk);

    // M < N sliding window, followed back-to-back by an accumulate tile
    run_tile("t2", 2, 'h0, 1'b0, 0, 0, 0);
    check_writes("t2", 'h0, 5, 5, 10, 0);
    for (int i = 0; i < 5 && i < wr_mask_q.size(); i++)
      chk($sformatf("t2_mask%0d", i), wr_mask_q[i], t2_mask[i]);

    run_tile("t3", 3, 'h20, 1'b1, 0, 0, 0);
    check_writes("t3", 'h20, 5, 6, 11, 1);
    chk("t3_nrd", rd_cyc_q.size(), 6);
    for (int i = 0; i < 6 && i < rd_cyc_q.size(); i++) begin
      chk($sformatf("t3_rcyc%0d", i), rd_cyc_q[i], 4 + i);
      chk($sformatf("t3_raddr%0d", i), rd_addr_q[i], 'h20 + i);
    end
    @(negedge clk);

    // Stall for 3 cycles where k=4 would otherwise be written
    run_tile("t4", 6, 'h10, 1'b0, 8, 3, 0);
    chk("t4_nwr", wr_cyc_q.size(), 9);
    chk("t4_done", done_cyc, 17);
    for (int i = 0; i < 9 && i < wr_cyc_q.size(); i++) begin
      chk($sformatf("t4_wcyc%0d", i), wr_cyc_q[i], t4_cyc[i]);
      chk($sformatf("t4_waddr%0d", i), wr_addr_q[i], 'h10 + i);
      chk($sformatf("t4_mask%0d", i), wr_mask_q[i], t1_mask[i]);
    end
    @(negedge clk);

    // Address wrap
    run_tile("t5", 4, 'h3FE, 1'b0, 0, 0, 0);
    check_writes("t5", 'h3FE, 5, 7, 12, 0);
    if (wr_addr_q.size() > 2) chk("t5_wrap", wr_addr_q[2], 'h000);
    @(negedge clk);

    // Empty tile: done pulse only
    run_tile("t6", 0, 'h55, 1'b1, 0, 0, 0);
    chk("t6_done", done_cyc, 1);
    chk("t6_nwr", wr_cyc_q.size(), 0);
    chk("t6_nrd", rd_cyc_q.size(), 0);
    @(negedge clk);

    // Start while busy is ignored
    run_tile("t7", 6, 'h10, 1'b0, 0, 0, 3);
    check_writes("t7", 'h10, 5, 9, 14, 0);
    @(negedge clk);

    // Asynchronous reset mid-OUTPUT
    rows  = CW'(6);
    base  = AW'('h40);
    acc   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t8_wr_before_reset", longint'(wr), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_reset_outputs", longint'(dut_vec), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Recovery after reset, accumulate with M=1
    run_tile("t9", 1, 'h7, 1'b1, 0, 0, 0);
    check_writes("t9", 'h7, 5, 4, 9, 1);
    for (int i = 0; i < 4 && i < wr_mask_q.size(); i++)
      chk($sformatf("t9_mask%0d", i), wr_mask_q[i], t9_mask[i]);
    chk("t9_nrd", rd_cyc_q.size(), 4);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
